z_capture_unit: RTL
===================

Z_CAPTURE_UNIT -- requirements
Module: z_capture_unit

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-transfer counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 Chigh  input  32  upper half of the ALU result.
REQ-005 Clow  input  32  lower half of the ALU result.
REQ-006 Zin  input  1  capture strobe for Chigh/Clow.
REQ-007 wide  input  1  sampled with Zin; 1 = MUL/DIV result (two words), 0 = single word.
REQ-008 bus_grant  input  1  bus accepts the current word this cycle.
REQ-009 err_clr  input  1  synchronous clear of capture_err.
REQ-010 ZHigh  output  32  registered upper half.
REQ-011 ZLow  output  32  registered lower half.
REQ-012 bus_req  output  1  word pending on bus_data.
REQ-013 bus_data  output  32  word offered to the bus.
REQ-014 dst_gp, dst_lo, dst_hi  output  1 each  one-hot destination of the offered word (GP register, LO, HI).
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 capture_err  output  1  sticky flag: a Zin was dropped.
REQ-017 xfer_cnt  output  CNT_W  count of completed results.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SEND_LO, SEND_HI.
REQ-019 Capture: when Zin=1 and capture is accepted, ZHigh<=Chigh, ZLow<=Clow, wide_q<=wide, and next state = SEND_LO.
REQ-020 Capture SHALL be accepted in IDLE, or in the final send cycle when bus_grant=1 (SEND_LO with wide_q=0, or SEND_HI); this gives back-to-back operation with no idle bubble.
REQ-021 In all other cases, Zin=1 SHALL be ignored: Z is unchanged and capture_err<=1.
REQ-022 Latency: bus_req SHALL rise in the cycle after the accepting edge.
REQ-023 SEND_LO outputs: bus_req=1 and bus_data=ZLow; dst_lo=wide_q and dst_gp=~wide_q.
REQ-024 SEND_LO transitions on bus_grant=1: to SEND_HI if wide_q=1; otherwise to IDLE, or stay in SEND_LO if a new capture is accepted.
REQ-025 SEND_LO and SEND_HI SHALL hold all outputs stable while bus_grant=0.
REQ-026 SEND_HI outputs: bus_req=1, bus_data=ZHigh, dst_hi=1.
REQ-027 SEND_HI transitions on bus_grant=1: to IDLE, or to SEND_LO if a new capture is accepted.
REQ-028 In IDLE: bus_req=0, bus_data=0, all dst_*=0; bus_grant SHALL be ignored.
REQ-029 dst_* SHALL be mutually exclusive, and all zero whenever bus_req=0.
REQ-030 xfer_cnt SHALL increment by 1 on each grant of the final word of a result, wrapping from 2^CNT_W-1 to 0.
REQ-031 capture_err precedence: if err_clr=1 and a dropped Zin occur in the same cycle, set wins.
REQ-032 ZHigh/ZLow SHALL change only on accepted capture or reset; ALU values are never passed through combinationally.

Reset
REQ-033 While clear=0, asynchronously and independent of clk: state=IDLE; ZHigh, ZLow, wide_q, xfer_cnt = 0; capture_err=0; all outputs reach their IDLE values.
REQ-034 Reset mid-transfer SHALL abandon the pending word(s); no grant is required after reset is released.
REQ-035 After clear rises, the first rising edge SHALL accept a Zin normally.

Verification
REQ-036 Narrow result: Zin=1, wide=0, Clow=0x0000_0025 -> next cycle bus_req=1, bus_data=0x25, dst_gp=1. Grant -> IDLE, xfer_cnt=1.
REQ-037 Wide result: Zin=1, wide=1, Chigh=0x1, Clow=0xFFFF_FFFE, grant withheld 3 cycles -> bus_data holds 0xFFFF_FFFE with dst_lo=1. Grant -> 0x1 with dst_hi=1. Grant -> IDLE, xfer_cnt=1.
REQ-038 Dropped capture: Zin during SEND_LO of a wide result without grant -> Z unchanged, capture_err=1. err_clr -> 0.
REQ-039 Back-to-back: Zin coincident with the SEND_HI grant (new Clow=0x7) -> next cycle SEND_LO with bus_data=0x7, no bubble, capture_err stays 0.
REQ-040 Async reset: clear=0 asserted mid-SEND_HI, between clock edges -> bus_req=0, ZHigh=ZLow=0 immediately. Counter wrap: 256 narrow transfers with CNT_W=8 -> xfer_cnt=0.

Source files
------------

// File: rtl/z_capture_unit.sv
// z_capture_unit: latches a one- or two-word ALU result and offers it to the bus word by word.
module z_capture_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [31:0]      Chigh,
  input  logic [31:0]      Clow,
  input  logic             Zin,
  input  logic             wide,
  input  logic             bus_grant,
  input  logic             err_clr,
  output logic [31:0]      ZHigh,
  output logic [31:0]      ZLow,
  output logic             bus_req,
  output logic [31:0]      bus_data,
  output logic             dst_gp,
  output logic             dst_lo,
  output logic             dst_hi,
  output logic             busy,
  output logic             capture_err,
  output logic [CNT_W-1:0] xfer_cnt
);
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_zhigh, r_zlow;
  logic             r_wide, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done, w_accept, w_drop;

  // The final word of a result is granted here; a new capture may ride on it.
  assign w_done   = bus_grant & ((r_state == SEND_LO & ~r_wide) | r_state == SEND_HI);
  assign w_accept = Zin & (r_state == IDLE | w_done);
  assign w_drop   = Zin & ~w_accept;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    bus_req  = 1'b0;
    bus_data = 32'd0;
    dst_gp   = 1'b0;
    dst_lo   = 1'b0;
    dst_hi   = 1'b0;
    if (w_accept) w_next = SEND_LO;
    else if (bus_grant && r_state == SEND_LO) w_next = r_wide ? SEND_HI : IDLE;
    else if (bus_grant && r_state == SEND_HI) w_next = IDLE;
    if (r_state == SEND_LO) begin
      bus_req  = 1'b1;
      bus_data = r_zlow;
      dst_lo   = r_wide;
      dst_gp   = ~r_wide;
    end else if (r_state == SEND_HI) begin
      bus_req  = 1'b1;
      bus_data = r_zhigh;
      dst_hi   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_zhigh <= 32'd0;
      r_zlow  <= 32'd0;
      r_wide  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_zhigh <= Chigh;
        r_zlow  <= Clow;
        r_wide  <= wide;
      end
      r_err <= w_drop ? 1'b1 : err_clr ? 1'b0 : r_err;
      r_cnt <= r_cnt + CNT_W'(w_done);
    end
  end

  assign ZHigh       = r_zhigh;
  assign ZLow        = r_zlow;
  assign busy        = r_state != IDLE;
  assign capture_err = r_err;
  assign xfer_cnt    = r_cnt;
endmodule
